p09_breakout_spi_master: RTL and testbench

//   SPI mode-0 (CPOL=0, CPHA=0) master that drives the breakout SPI slave interface
//   (sck/ss/mosi in, miso out) from a test harness or companion controller.

---
 rtl/p09_breakout_spi_master.sv | 188 ++++++++++++++++++
 tb/tb_p09_breakout_spi_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p09_breakout_spi_master.sv
`default_nettype none
// =============================================================================
// Module      : p09_breakout_spi_master
// Description : SPI mode-0 master. Streams bytes MSB-first from a valid/ready
//               port and returns the byte captured on miso; ss_n spans bursts.
// Revision    : 1.0 - initial release
// =============================================================================
module p09_breakout_spi_master #(
    parameter int CLK_DIV        = 4,
    parameter int DATA_W         = 8,
    parameter int SS_IDLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sck,
    output logic              ss_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int c_CNT_MAX = (CLK_DIV > SS_IDLE_CYCLES) ? CLK_DIV : SS_IDLE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_BIT_W   = $clog2(2 * DATA_W + 1);

    localparam logic [c_CNT_W-1:0] c_DIV_LAST  = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(SS_IDLE_CYCLES - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_FINAL = c_BIT_W'(2 * DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_FULL  = c_BIT_W'(2 * DATA_W);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SHIFT = 3'd1;
    localparam logic [2:0] c_NEXT  = 3'd2;
    localparam logic [2:0] c_TRAIL = 3'd3;
    localparam logic [2:0] c_GAP   = 3'd4;

    logic [2:0]        r_state,    w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [c_BIT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_W-1:0] r_tx_sh,    w_tx_sh_nxt;
    logic [DATA_W-1:0] r_rx_sh,    w_rx_sh_nxt;
    logic [DATA_W-1:0] r_rx_data,  w_rx_data_nxt;
    logic              r_last,     w_last_nxt;
    logic              r_sck,      w_sck_nxt;
    logic              r_ss_n,     w_ss_n_nxt;
    logic              r_mosi,     w_mosi_nxt;
    logic              r_tx_ready, w_tx_ready_nxt;
    logic              r_rx_valid, w_rx_valid_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              w_accept;

    assign w_accept = tx_valid && r_tx_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tx_sh_nxt    = r_tx_sh;
        w_rx_sh_nxt    = r_rx_sh;
        w_rx_data_nxt  = r_rx_data;
        w_last_nxt     = r_last;
        w_sck_nxt      = r_sck;
        w_ss_n_nxt     = r_ss_n;
        w_mosi_nxt     = r_mosi;
        w_tx_ready_nxt = r_tx_ready;
        w_rx_valid_nxt = 1'b0;
        w_busy_nxt     = r_busy;

        case (r_state)
            c_IDLE, c_NEXT: begin
                if (w_accept) begin
                    w_state_nxt    = c_SHIFT;
                    w_cnt_nxt      = '0;
                    w_bit_cnt_nxt  = '0;
                    w_tx_sh_nxt    = tx_data;
                    w_last_nxt     = tx_last;
                    w_sck_nxt      = 1'b0;
                    w_ss_n_nxt     = 1'b0;
                    w_mosi_nxt     = tx_data[DATA_W-1];
                    w_tx_ready_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end
            c_SHIFT: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt_nxt = '0;
                    w_sck_nxt = ~r_sck;
                    if (r_bit_cnt != c_BIT_FULL) begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                    if (!r_sck) begin
                        w_rx_sh_nxt = {r_rx_sh[DATA_W-2:0], miso};
                    end else if (r_bit_cnt == c_BIT_FINAL) begin
                        // Final falling edge: hand the byte out and leave SHIFT.
                        w_rx_data_nxt  = r_rx_sh;
                        w_rx_valid_nxt = 1'b1;
                        if (r_last) begin
                            w_state_nxt = c_TRAIL;
                        end else begin
                            w_state_nxt    = c_NEXT;
                            w_tx_ready_nxt = 1'b1;
                        end
                    end else begin
                        w_tx_sh_nxt = r_tx_sh << 1;
                        w_mosi_nxt  = r_tx_sh[DATA_W-2];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_TRAIL: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt_nxt   = '0;
                    w_ss_n_nxt  = 1'b1;
                    w_state_nxt = c_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_cnt_nxt      = '0;
                    w_state_nxt    = c_IDLE;
                    w_tx_ready_nxt = 1'b1;
                    w_busy_nxt     = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = c_IDLE;
                w_cnt_nxt      = '0;
                w_sck_nxt      = 1'b0;
                w_ss_n_nxt     = 1'b1;
                w_tx_ready_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_last     <= 1'b0;
            r_sck      <= 1'b0;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_last     <= w_last_nxt;
            r_sck      <= w_sck_nxt;
            r_ss_n     <= w_ss_n_nxt;
            r_mosi     <= w_mosi_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign sck      = r_sck;
    assign ss_n     = r_ss_n;
    assign mosi     = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_p09_breakout_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module      : tb_p09_breakout_spi_master
// Description : Scoreboard bench for the SPI master with a mode-0 slave model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_p09_breakout_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, rx_valid, busy, sck, ss_n, mosi, miso;
    logic [7:0] rx_data;

    logic [7:0] tx_data_f = '0;
    logic       tx_valid_f = 1'b0;
    logic       tx_last_f = 1'b0;
    logic       miso_f = 1'b1;
    logic       tx_ready_f, rx_valid_f, busy_f, sck_f, ss_n_f, mosi_f;
    logic [7:0] rx_data_f;

    p09_breakout_spi_master #(.CLK_DIV(4), .DATA_W(8), .SS_IDLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    p09_breakout_spi_master #(.CLK_DIV(1), .DATA_W(8), .SS_IDLE_CYCLES(2)) dut_fast (
        .clk(clk), .rst(rst), .tx_data(tx_data_f), .tx_valid(tx_valid_f), .tx_last(tx_last_f),
        .tx_ready(tx_ready_f), .rx_data(rx_data_f), .rx_valid(rx_valid_f), .busy(busy_f),
        .sck(sck_f), .ss_n(ss_n_f), .mosi(mosi_f), .miso(miso_f)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_mosi_q[$];
    logic [7:0] resp_q[$];

    // Slave model state: response shifter drives miso, s_rx collects mosi
    logic [7:0] s_sh = '0;
    logic [7:0] s_rx = '0;
    int         s_cnt = 0;
    logic       s_need = 1'b1;
    assign miso = s_sh[7];

    logic prev_sck = 1'b0, prev_ss = 1'b1, prev_rdy = 1'b1, prev_busy = 1'b0, first_pend = 1'b0;
    int   acc_cyc = 0, ss_fall_cyc = 0, ss_rise_cyc = 0, rdy_rise_cyc = 0, busy_rise_cyc = 0;
    int   first_rise_cyc = 0, fall_cyc = 0;
    int   rise_cnt = 0, rxv_cnt = 0, ss_fall_cnt = 0, ready_viol = 0;

    logic       prev_sck_f = 1'b0, prev_ss_f = 1'b1;
    int         ss_fall_f = 0, fall_f = 0, rise1_f = 0, rise2_f = 0, rise_cnt_f = 0, rxv_cnt_f = 0;
    logic [7:0] mosi_cap_f = '0, rx_last_f = '0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of progress; all observation happens on the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst) begin
            exp_rx_q.delete();
            exp_mosi_q.delete();
            resp_q.delete();
            s_need     = 1'b1;
            s_cnt      = 0;
            first_pend = 1'b0;
        end else begin
            if (prev_ss && !ss_n) begin
                ss_fall_cyc = cyc;
                ss_fall_cnt++;
                first_pend = 1'b1;
            end
            if (!prev_ss && ss_n) ss_rise_cyc = cyc;
            if (!prev_rdy && tx_ready && ss_n) rdy_rise_cyc = cyc;
            if (!prev_busy && busy) busy_rise_cyc = cyc;
            if (!prev_sck && sck) begin
                rise_cnt++;
                if (first_pend) first_rise_cyc = cyc;
                first_pend = 1'b0;
                s_rx = {s_rx[6:0], mosi};
                s_sh = s_sh << 1;
                s_cnt++;
                if (s_cnt == 8) begin
                    s_cnt  = 0;
                    s_need = 1'b1;
                    if (exp_mosi_q.size() == 0) chk_eq("mosi_extra_byte", 1, 0);
                    else chk_eq("mosi_byte", s_rx, exp_mosi_q.pop_front());
                end
            end
            if (prev_sck && !sck) fall_cyc = cyc;
            if (sck && tx_ready) ready_viol++;
            if (rx_valid) begin
                rxv_cnt++;
                if (exp_rx_q.size() == 0) chk_eq("rx_spurious", 1, 0);
                else chk_eq("rx_data", rx_data, exp_rx_q.pop_front());
            end
            if (s_need && resp_q.size() > 0) begin
                s_sh   = resp_q.pop_front();
                s_need = 1'b0;
            end
        end
        prev_sck  = sck;
        prev_ss   = ss_n;
        prev_rdy  = tx_ready;
        prev_busy = busy;

        if (prev_ss_f && !ss_n_f) ss_fall_f = cyc;
        if (!prev_sck_f && sck_f) begin
            rise_cnt_f++;
            if (rise_cnt_f == 1) rise1_f = cyc;
            if (rise_cnt_f == 2) rise2_f = cyc;
            mosi_cap_f = {mosi_cap_f[6:0], mosi_f};
        end
        if (prev_sck_f && !sck_f) fall_f = cyc;
        if (rx_valid_f) begin
            rxv_cnt_f++;
            rx_last_f = rx_data_f;
        end
        prev_sck_f = sck_f;
        prev_ss_f  = ss_n_f;
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] r, input logic l);
        int n = 0;
        resp_q.push_back(r);
        exp_mosi_q.push_back(d);
        exp_rx_q.push_back(r);
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        while (!tx_ready && n < 400) begin
            tick();
            n++;
        end
        if (!tx_ready) chk_eq("send_timeout", 1, 0);
        else acc_cyc = cyc;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        if (busy) chk_eq("idle_timeout", 1, 0);
    endtask

    initial begin
        int base_r, base_rx, base_ss, hold_bad, n;
        logic [7:0] d, r;

        repeat (3) tick();
        chk_eq("rst_ctrl", {sck, ss_n, mosi, tx_ready, rx_valid, busy}, 6'b010100);
        chk_eq("rst_rx_data", rx_data, 0);
        chk_eq("rst_ctrl_fast", {sck_f, ss_n_f, mosi_f, tx_ready_f, rx_valid_f, busy_f}, 6'b010100);
        rst = 1'b0;
        repeat (2) tick();

        // Single last byte: exact timing of every phase
        base_rx = rxv_cnt;
        send(8'hA5, 8'h3C, 1'b1);
        wait_idle();
        repeat (2) tick();
        chk_eq("t1_ss_fall", ss_fall_cyc - acc_cyc, 1);
        chk_eq("t1_busy_rise", busy_rise_cyc - acc_cyc, 1);
        chk_eq("t1_first_rise", first_rise_cyc - ss_fall_cyc, 4);
        chk_eq("t1_final_fall", fall_cyc - ss_fall_cyc, 64);
        chk_eq("t1_ss_rise", ss_rise_cyc - fall_cyc, 4);
        chk_eq("t1_ready_rise", rdy_rise_cyc - ss_rise_cyc, 2);
        chk_eq("t1_rx_count", rxv_cnt - base_rx, 1);

        // Three-byte burst under one ss_n assertion
        base_r = rise_cnt; base_rx = rxv_cnt; base_ss = ss_fall_cnt;
        send(8'h01, 8'hC1, 1'b0);
        send(8'h02, 8'hC2, 1'b0);
        send(8'h03, 8'hC3, 1'b1);
        wait_idle();
        chk_eq("t2_rises", rise_cnt - base_r, 24);
        chk_eq("t2_rx_count", rxv_cnt - base_rx, 3);
        chk_eq("t2_ss_falls", ss_fall_cnt - base_ss, 1);

        // Stall in NEXT with no new byte
        base_rx = rxv_cnt;
        send(8'h5A, 8'h96, 1'b0);
        n = 0;
        while (rxv_cnt == base_rx && n < 400) begin
            tick();
            n++;
        end
        chk_eq("t3_first_rx", rxv_cnt - base_rx, 1);
        hold_bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ss_n !== 1'b0 || sck !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0) hold_bad++;
        end
        chk_eq("t3_hold", hold_bad, 0);
        send(8'h33, 8'hE7, 1'b1);
        wait_idle();
        chk_eq("t3_rx_count", rxv_cnt - base_rx, 2);

        // Next byte held valid through SHIFT: nothing lost or duplicated
        base_r = rise_cnt; base_rx = rxv_cnt;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            r = 8'($urandom_range(0, 255));
            send(d, r, i == 3);
        end
        wait_idle();
        chk_eq("t6_rises", rise_cnt - base_r, 32);
        chk_eq("t6_rx_count", rxv_cnt - base_rx, 4);

        // Reset mid-byte, then a clean transfer
        base_r = rise_cnt; base_rx = rxv_cnt;
        send(8'h77, 8'h00, 1'b1);
        n = 0;
        while (rise_cnt < base_r + 3 && n < 400) begin
            tick();
            n++;
        end
        rst = 1'b1;
        #1;
        chk_eq("t4_async", {sck, ss_n}, 2'b01);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk_eq("t4_no_rx", rxv_cnt - base_rx, 0);
        chk_eq("t4_ctrl", {sck, ss_n, tx_ready, busy}, 4'b0110);
        send(8'hFF, 8'h81, 1'b1);
        wait_idle();
        chk_eq("t4_rx_count", rxv_cnt - base_rx, 1);

        // CLK_DIV=1 instance
        tx_data_f  = 8'h80;
        tx_last_f  = 1'b1;
        tx_valid_f = 1'b1;
        base_r = cyc;
        tick();
        tx_valid_f = 1'b0;
        n = 0;
        while (busy_f && n < 200) begin
            tick();
            n++;
        end
        chk_eq("t5_idle", busy_f, 0);
        chk_eq("t5_ss_fall", ss_fall_f - base_r, 1);
        chk_eq("t5_first_rise", rise1_f - ss_fall_f, 1);
        chk_eq("t5_period", rise2_f - rise1_f, 2);
        chk_eq("t5_final_fall", fall_f - ss_fall_f, 16);
        chk_eq("t5_mosi", mosi_cap_f, 8'h80);
        chk_eq("t5_rises", rise_cnt_f, 8);
        chk_eq("t5_rx_count", rxv_cnt_f, 1);
        chk_eq("t5_rx_data", rx_last_f, 8'hFF);

        repeat (4) tick();
        chk_eq("ready_in_shift", ready_viol, 0);
        chk_eq("sb_rx_left", exp_rx_q.size(), 0);
        chk_eq("sb_mosi_left", exp_mosi_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
